gpio_pad_controller: RTL and testbench

- Core-side controller for a bank of WIDTH generic digital GPIO pad cells.
- Registers the pad-drive controls `o`/`oe`/`ie` toward the cells so pad drive is glitch-free.
- Synchronizes and debounces the cells' `i` returns and reports the debounced levels.
- Raises a level interrupt on per-pin rising and/or falling edges. Sits between the core's GPIO register block and the IO cell ring.

---
 rtl/gpio_pad_controller.sv | 114 +++++++++++
 tb/tb_gpio_pad_controller.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pad_controller.sv
// gpio_pad_controller
// Core-side controller for a bank of generic GPIO pad cells. Registers the
// pad drive controls, synchronizes and debounces the pad input returns, and
// raises a sticky per-pin edge interrupt with write-1-to-clear semantics.
module gpio_pad_controller #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] core_o,
  input  logic [WIDTH-1:0] core_oe,
  input  logic [WIDTH-1:0] core_ie,
  output logic [WIDTH-1:0] cell_o,
  output logic [WIDTH-1:0] cell_oe,
  output logic [WIDTH-1:0] cell_ie,
  input  logic [WIDTH-1:0] cell_i,
  output logic [WIDTH-1:0] in_value,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] irq_clear,
  output logic [WIDTH-1:0] irq_pending,
  output logic             irq
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;
  logic [CNT_W-1:0] cnt_q  [WIDTH];
  logic [CNT_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0] in_d;
  logic [WIDTH-1:0] rise_evt;
  logic [WIDTH-1:0] fall_evt;
  logic [WIDTH-1:0] set_pending;

  // Drive path: every pad control is a flop so the pads never see core-side glitches.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cell_o  <= '0;
      cell_oe <= '0;
      cell_ie <= '0;
    end else begin
      cell_o  <= core_o;
      cell_oe <= core_oe;
      cell_ie <= core_ie;
    end
  end

  // Input synchronizer: every stage is zeroed while the pin's input is disabled,
  // so re-enabling always starts from a clean low and stale samples are flushed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= cell_i & cell_ie;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1] & cell_ie;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Debounce decision: a new level is accepted only after it has differed from
  // the stable level for DEBOUNCE_CYCLES consecutive samples; acceptance is the edge event.
  always_comb begin
    cnt_d    = cnt_q;
    in_d     = in_value;
    rise_evt = '0;
    fall_evt = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (!cell_ie[b]) begin
        cnt_d[b] = '0;
        in_d[b]  = 1'b0;
      end else if (sync_out[b] == in_value[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == CNT_LAST) begin
        cnt_d[b]    = '0;
        in_d[b]     = sync_out[b];
        rise_evt[b] = sync_out[b];
        fall_evt[b] = ~sync_out[b];
      end else begin
        cnt_d[b] = cnt_q[b] + CNT_ONE;
      end
    end
  end

  // Debounce state: per-pin run counters and the accepted stable levels.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < WIDTH; b++) cnt_q[b] <= '0;
      in_value <= '0;
    end else begin
      for (int b = 0; b < WIDTH; b++) cnt_q[b] <= cnt_d[b];
      in_value <= in_d;
    end
  end

  assign set_pending = (rise_evt & rise_en) | (fall_evt & fall_en);

  // Sticky interrupt flags: a same-edge set overrides a clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irq_pending <= '0;
    end else begin
      irq_pending <= (irq_pending & ~irq_clear) | set_pending;
    end
  end

  assign irq = |irq_pending;

endmodule

// File: tb/tb_gpio_pad_controller.sv
// Testbench for gpio_pad_controller: directed scenarios plus a randomized soak,
// all checked against a window-based reference model of the pad controller.
module tb_gpio_pad_controller;

  localparam int W    = 8;
  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] core_o = '0, core_oe = '0, core_ie = '0;
  logic [W-1:0] cell_i = '0, rise_en = '0, fall_en = '0, irq_clear = '0;
  logic [W-1:0] cell_o, cell_oe, cell_ie, in_value, irq_pending;
  logic         irq;

  int vectors = 0;
  int miscompares = 0;

  gpio_pad_controller #(
    .WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .core_o(core_o), .core_oe(core_oe), .core_ie(core_ie),
    .cell_o(cell_o), .cell_oe(cell_oe), .cell_ie(cell_ie),
    .cell_i(cell_i), .in_value(in_value),
    .rise_en(rise_en), .fall_en(fall_en), .irq_clear(irq_clear),
    .irq_pending(irq_pending), .irq(irq)
  );

  always #5 clock = ~clock;

  // Reference model: pad regs are one-edge copies, the sampled level is the
  // cell input delayed SYNC edges, and a pin accepts a new level when the last
  // DEB samples it saw all differ from its current level.
  logic [W-1:0] m_o, m_oe, m_ie, m_in, m_pend;
  logic [W-1:0] m_sync [SYNC];
  logic [W-1:0] hist [$];
  logic [W-1:0] samp, nin, hb;
  bit           all_diff;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_o = '0; m_oe = '0; m_ie = '0; m_in = '0; m_pend = '0;
      for (int s = 0; s < SYNC; s++) m_sync[s] = '0;
      hist.delete();
    end else begin
      samp = m_sync[SYNC-1] & m_ie;
      hist.push_front(samp);
      if (hist.size() > DEB) void'(hist.pop_back());
      nin = m_in;
      for (int b = 0; b < W; b++) begin
        if (!m_ie[b]) nin[b] = 1'b0;
        else if (hist.size() == DEB) begin
          all_diff = 1'b1;
          for (int k = 0; k < DEB; k++) begin
            hb = hist[k];
            if (hb[b] == m_in[b]) all_diff = 1'b0;
          end
          if (all_diff) nin[b] = ~m_in[b];
        end
      end
      m_pend = (m_pend & ~irq_clear) | (nin & ~m_in & m_ie & rise_en)
             | (~nin & m_in & m_ie & fall_en);
      m_in = nin;
      for (int s = SYNC - 1; s > 0; s--) m_sync[s] = m_sync[s-1] & m_ie;
      m_sync[0] = cell_i & m_ie;
      m_o = core_o; m_oe = core_oe; m_ie = core_ie;
    end
  end

  wire [6*W:0] obs   = {cell_o, cell_oe, cell_ie, in_value, irq_pending, irq};
  wire [6*W:0] exp_v = {m_o, m_oe, m_ie, m_in, m_pend, |m_pend};

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut();
    reset_n = 1'b0;
    core_o = '0; core_oe = '0; core_ie = '0;
    cell_i = '0; rise_en = '0; fall_en = '0; irq_clear = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    core_o = W'($urandom); core_oe = 8'hFF; core_ie = 8'hFF; cell_i = W'($urandom);
    repeat (3) @(negedge clock);
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_hold: got %h expected %h", obs, {(6*W+1){1'b0}});
    end
    reset_n = 1'b1;
    core_o = 8'hA5; core_oe = 8'h0F; core_ie = 8'hF0;
    @(negedge clock);
    vectors++;
    if ({cell_o, cell_oe, cell_ie} !== 24'hA50FF0) begin
      miscompares++;
      $display("FAIL drive_after_reset: got %h expected a50ff0", {cell_o, cell_oe, cell_ie});
    end
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL drive_model: got %h expected %h", obs, exp_v);
    end
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got %h expected 0", obs);
    end
  endtask

  task automatic test_clean_rise();
    reset_dut();
    core_ie = 8'h01; rise_en = 8'h01; core_o = W'($urandom); core_oe = W'($urandom);
    repeat (6) begin
      @(negedge clock);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL rise_settle: got %h expected %h", obs, exp_v);
      end
    end
    cell_i = 8'h01;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clock);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL rise_model edge %0d: got %h expected %h", e, obs, exp_v);
      end
      vectors++;
      if ({in_value[0], irq_pending[0], irq} !== {3{e >= SYNC + DEB}}) begin
        miscompares++;
        $display("FAIL rise_latency edge %0d: got %b expected %b", e,
                 {in_value[0], irq_pending[0], irq}, {3{e >= SYNC + DEB}});
      end
    end
    irq_clear = 8'h01;
    @(negedge clock);
    irq_clear = '0;
    vectors++;
    if ({irq_pending[0], irq, in_value[0]} !== 3'b001) begin
      miscompares++;
      $display("FAIL rise_clear: got %b expected 001", {irq_pending[0], irq, in_value[0]});
    end
  endtask

  task automatic test_glitch();
    int glen;
    int highs;
    reset_dut();
    core_ie = 8'h08; rise_en = 8'h08; fall_en = 8'h08;
    repeat (4) @(negedge clock);
    glen = $urandom_range(1, DEB - 1);
    cell_i = 8'h08;
    for (int c = 0; c < glen + 10; c++) begin
      @(negedge clock);
      if (c == glen - 1) cell_i = '0;
      vectors++;
      if (obs !== exp_v || in_value[3] !== 1'b0 || irq_pending[3] !== 1'b0) begin
        miscompares++;
        $display("FAIL glitch_%0d: got %h expected %h", glen, obs, exp_v);
      end
    end
    highs = 0;
    cell_i = 8'h08;
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      if (c == DEB - 1) cell_i = '0;
      if (in_value[3]) highs++;
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL pulse_model cyc %0d: got %h expected %h", c, obs, exp_v);
      end
    end
    vectors++;
    if (highs != DEB || irq_pending[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL pulse_width: got %0d high cycles pend %b expected %0d pend 1",
               highs, irq_pending[3], DEB);
    end
  endtask

  task automatic test_fall_only();
    reset_dut();
    core_ie = 8'h04; fall_en = 8'h04; rise_en = W'($urandom) & ~8'h04;
    cell_i = 8'h04;
    repeat (10) begin
      @(negedge clock);
      vectors++;
      if (obs !== exp_v || irq_pending[2] !== 1'b0) begin
        miscompares++;
        $display("FAIL fall_only_rise: got %h expected %h", obs, exp_v);
      end
    end
    cell_i = '0;
    repeat (10) begin
      @(negedge clock);
      vectors++;
      if (obs !== exp_v || irq_pending[2] !== ~in_value[2]) begin
        miscompares++;
        $display("FAIL fall_only_fall: got %h expected %h", obs, exp_v);
      end
    end
    vectors++;
    if ({in_value[2], irq_pending[2]} !== 2'b01) begin
      miscompares++;
      $display("FAIL fall_only_end: got %b expected 01", {in_value[2], irq_pending[2]});
    end
  endtask

  task automatic test_collision();
    reset_dut();
    core_ie = 8'h20; rise_en = 8'h20;
    repeat (4) @(negedge clock);
    cell_i = 8'h20;
    for (int e = 1; e <= SYNC + DEB + 2; e++) begin
      irq_clear = (e == SYNC + DEB) ? 8'h20 : 8'h00;
      @(negedge clock);
      vectors++;
      if (obs !== exp_v || irq_pending[5] !== (e >= SYNC + DEB)) begin
        miscompares++;
        $display("FAIL collision edge %0d: got %h expected %h", e, obs, exp_v);
      end
    end
    irq_clear = 8'h20;
    @(negedge clock);
    irq_clear = '0;
    vectors++;
    if (irq_pending[5] !== 1'b0 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL collision_clear: got %b expected 00", {irq_pending[5], irq});
    end
  endtask

  task automatic test_input_disable();
    reset_dut();
    core_ie = 8'h40; fall_en = 8'h40; cell_i = 8'h40;
    repeat (10) @(negedge clock);
    vectors++;
    if ({in_value[6], irq_pending[6]} !== 2'b10) begin
      miscompares++;
      $display("FAIL disable_setup: got %b expected 10", {in_value[6], irq_pending[6]});
    end
    core_ie = '0;
    repeat (4) begin
      @(negedge clock);
      vectors++;
      if (obs !== exp_v || irq_pending[6] !== 1'b0) begin
        miscompares++;
        $display("FAIL disable_drop: got %h expected %h", obs, exp_v);
      end
    end
    vectors++;
    if (in_value[6] !== 1'b0) begin
      miscompares++;
      $display("FAIL disable_level: got %b expected 0", in_value[6]);
    end
    rise_en = 8'h40; core_ie = 8'h40;
    repeat (10) begin
      @(negedge clock);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL reenable: got %h expected %h", obs, exp_v);
      end
    end
    vectors++;
    if ({in_value[6], irq_pending[6]} !== 2'b11) begin
      miscompares++;
      $display("FAIL reenable_end: got %b expected 11", {in_value[6], irq_pending[6]});
    end
  endtask

  task automatic test_random();
    reset_dut();
    core_ie = W'($urandom); rise_en = W'($urandom); fall_en = W'($urandom);
    for (int c = 0; c < 800; c++) begin
      @(negedge clock);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %h expected %h", c, obs, exp_v);
      end
      if (c == 400) begin
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (obs !== '0) begin
          miscompares++;
          $display("FAIL random_async_reset: got %h expected 0", obs);
        end
        @(negedge clock);
        reset_n = 1'b1;
      end
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 9) == 0) cell_i[b] = ~cell_i[b];
      core_o = W'($urandom); core_oe = W'($urandom);
      if ($urandom_range(0, 39) == 0) core_ie = W'($urandom);
      if ($urandom_range(0, 29) == 0) rise_en = W'($urandom);
      if ($urandom_range(0, 29) == 0) fall_en = W'($urandom);
      irq_clear = W'($urandom) & W'($urandom) & W'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_clean_rise();
    test_glitch();
    test_fall_only();
    test_collision();
    test_input_disable();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
